// File: rtl/program_mem.sv
// ---------------------------------------------------------------------------
// program_mem
//   Fixed-content instruction ROM with a registered output word.
//
//   Ports
//     clk    in   1          system clock, rising-edge active
//     res_n  in   1          asynchronous reset, active HIGH despite the name
//     pc     in   PC_WIDTH   instruction address
//     ir     out  DataWidth  instruction word, one cycle after pc is sampled
//
//   Addresses 0..14 hold the program. The rest of 0..CMD_CNT-1 reads as
//   zero, and so does any pc >= CMD_CNT.
// ---------------------------------------------------------------------------
module program_mem #(
    parameter int PC_WIDTH  = 8,
    parameter int DataWidth = 16,
    parameter int CMD_CNT   = 64
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic [DataWidth-1:0] ir
);

    logic [DataWidth-1:0] r_ir;
    logic [DataWidth-1:0] w_rom_word;
    logic [DataWidth-1:0] w_next_ir;
    logic [31:0]          w_addr;
    logic                 w_in_range;

    // The address is widened so that it compares against CMD_CNT at full
    // width. A high-order pc bit can therefore never fold onto a low ROM
    // address.
    assign w_addr     = 32'(pc);
    assign w_in_range = (w_addr < 32'(CMD_CNT));

    always_comb begin
        w_rom_word = '0;
        case (w_addr)
            32'd0:   w_rom_word = DataWidth'(16'h4903);
            32'd1:   w_rom_word = DataWidth'(16'h4A14);
            32'd2:   w_rom_word = DataWidth'(16'h4BF0);
            32'd3:   w_rom_word = DataWidth'(16'h0910);
            32'd4:   w_rom_word = DataWidth'(16'h1918);
            32'd5:   w_rom_word = DataWidth'(16'h480F);
            32'd6:   w_rom_word = DataWidth'(16'h2008);
            32'd7:   w_rom_word = DataWidth'(16'h2918);
            32'd8:   w_rom_word = DataWidth'(16'h3308);
            32'd9:   w_rom_word = DataWidth'(16'h1308);
            32'd10:  w_rom_word = DataWidth'(16'h0000);
            32'd11:  w_rom_word = DataWidth'(16'h0000);
            32'd12:  w_rom_word = DataWidth'(16'h3902);
            32'd13:  w_rom_word = DataWidth'(16'h4204);
            32'd14:  w_rom_word = DataWidth'(16'h8008);
            default: w_rom_word = '0;
        endcase
    end

    // Gate the ROM word with the range check. A CMD_CNT smaller than the
    // program then hides the upper entries.
    assign w_next_ir = w_in_range ? w_rom_word : '0;

    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            r_ir <= '0;
        end else begin
            r_ir <= w_next_ir;
        end
    end

    assign ir = r_ir;

endmodule

// File: tb/tb_program_mem.sv
module tb_program_mem;

    logic        clk;
    logic        res_n;
    logic [7:0]  pc;
    logic [15:0] ir;

    int unsigned errors;
    int unsigned checks;

    program_mem #(
        .PC_WIDTH  (8),
        .DataWidth (16),
        .CMD_CNT   (64)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .pc    (pc),
        .ir    (ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the program listing plus the "everything else is zero" rule.
    function automatic logic [15:0] ref_word(input int unsigned addr);
        logic [15:0] prog [15];
        prog = '{16'h4903, 16'h4A14, 16'h4BF0, 16'h0910, 16'h1918,
                 16'h480F, 16'h2008, 16'h2918, 16'h3308, 16'h1308,
                 16'h0000, 16'h0000, 16'h3902, 16'h4204, 16'h8008};
        if (addr < 15) return prog[addr];
        return 16'h0000;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_n = 1'b1;
        pc    = 8'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ir !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: ir=%h expected=0000", i, ir);
            end
            pc = 8'(i + 1);
        end
        pc = 8'd0;
    endtask

    task automatic test_release_and_sweep();
        pc = 8'd0;
        res_n = 1'b0;
        for (int a = 0; a <= 14; a++) begin
            pc = 8'(a);
            step();
            checks++;
            if (ir !== ref_word(a)) begin
                errors++;
                $display("FAIL sweep pc=%0d: ir=%h expected=%h", a, ir, ref_word(a));
            end
        end
    endtask

    task automatic test_pc_change_between_edges();
        pc = 8'd0;
        step();
        checks++;
        if (ir !== 16'h4903) begin
            errors++;
            $display("FAIL hold_pre: ir=%h expected=4903", ir);
        end
        pc = 8'd5;
        #3;
        checks++;
        if (ir !== 16'h4903) begin
            errors++;
            $display("FAIL hold_mid: ir=%h expected=4903", ir);
        end
        step();
        checks++;
        if (ir !== 16'h480F) begin
            errors++;
            $display("FAIL hold_post: ir=%h expected=480F", ir);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] addrs [4];
        addrs = '{8'd15, 8'd63, 8'd64, 8'd255};
        for (int i = 0; i < 4; i++) begin
            // Load a nonzero word first so that a zero read means something.
            pc = 8'd1;
            step();
            pc = addrs[i];
            step();
            checks++;
            if (ir !== 16'h0000) begin
                errors++;
                $display("FAIL out_of_range pc=%0d: ir=%h expected=0000", addrs[i], ir);
            end
        end
    endtask

    task automatic test_reset_midsequence();
        pc = 8'd12;
        step();
        checks++;
        if (ir !== 16'h3902) begin
            errors++;
            $display("FAIL mid_pre: ir=%h expected=3902", ir);
        end
        #2;
        res_n = 1'b1;
        #1;
        checks++;
        if (ir !== 16'h0000) begin
            errors++;
            $display("FAIL mid_async_clear: ir=%h expected=0000", ir);
        end
        step();
        checks++;
        if (ir !== 16'h0000) begin
            errors++;
            $display("FAIL mid_held: ir=%h expected=0000", ir);
        end
        pc    = 8'd13;
        res_n = 1'b0;
        step();
        checks++;
        if (ir !== 16'h4204) begin
            errors++;
            $display("FAIL mid_resume: ir=%h expected=4204", ir);
        end
    endtask

    task automatic test_random();
        int unsigned a;
        for (int i = 0; i < 300; i++) begin
            // Bias half of the addresses into the programmed region.
            if ($urandom_range(1, 0) == 1) a = $urandom_range(15, 0);
            else                           a = $urandom_range(255, 0);
            pc = 8'(a);
            step();
            checks++;
            if (ir !== ref_word(a)) begin
                errors++;
                $display("FAIL random[%0d] pc=%0d: ir=%h expected=%h", i, a, ir, ref_word(a));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        res_n  = 1'b1;
        pc     = 8'd0;
        test_reset();
        test_release_and_sweep();
        test_pc_change_between_edges();
        test_out_of_range();
        test_reset_midsequence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_mem.md
PROGRAM_MEM -- requirements
Module: Program_Mem

Parameters
REQ-001 PC_WIDTH, default 8, width of the program-counter address input.
REQ-002 DataWidth, default 16, width of one instruction word.
REQ-003 CMD_CNT, default 64, number of implemented ROM words (addresses 0..CMD_CNT-1).

Interface
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 res_n  input  1  reset; asynchronous, active-high (asserted when 1), despite the _n suffix in the port name.
REQ-006 pc  input  PC_WIDTH  instruction address.
REQ-007 ir  output  DataWidth  registered instruction word.

Function
REQ-008 The block SHALL be a read-only instruction memory with fixed contents, not writable at run time.
REQ-009 ROM contents (hex) SHALL be: addr0 4903, addr1 4A14, addr2 4BF0, addr3 0910, addr4 1918, addr5 480F, addr6 2008, addr7 2918.
REQ-010 ROM contents SHALL continue: addr8 3308, addr9 1308, addr10 0000, addr11 0000, addr12 3902, addr13 4204, addr14 8008.
REQ-011 Addresses 15..CMD_CNT-1 SHALL hold 0000.
REQ-012 Any pc >= CMD_CNT (64..255 at defaults) SHALL read 0000, never X and never aliased.
REQ-013 While reset is deasserted, on each rising clk edge ir SHALL load ROM[pc] sampled at that edge (1-cycle read latency).
REQ-014 ir SHALL hold its value between rising edges; a pc change alone SHALL NOT alter ir until the next rising edge.
REQ-015 Consecutive distinct addresses on consecutive cycles SHALL each appear on ir exactly one edge later (full throughput, no stalls).
REQ-016 Repeated reads of the same address SHALL return the same word.
REQ-017 ir SHALL never be X/Z after reset has been applied once.

Reset
REQ-018 When res_n=1, ir SHALL go to 0000 immediately, independent of clk.
REQ-019 While res_n=1, ir SHALL remain 0000 regardless of clk edges and pc.
REQ-020 On the first rising edge after res_n returns to 0, ir SHALL load ROM[pc].
REQ-021 Reset SHALL NOT alter ROM contents; a reset mid-sequence followed by release SHALL resume correct reads.

Verification
REQ-022 Assert res_n=1 with pc=0, toggle clk -> ir=0000 throughout, including mid-cycle assertion (async clear).
REQ-023 Release reset with pc=0, rising edge -> ir=4903; set pc=1, next edge -> ir=4A14; pc=2 -> 4BF0.
REQ-024 Sweep pc=3..14, one address per cycle -> ir one edge later = 0910, 1918, 480F, 2008, 2918, 3308, 1308, 0000, 0000, 3902, 4204, 8008.
REQ-025 Change pc between edges (pc 0->5 after a rising edge) -> ir stays 4903 until the next rising edge, then 480F.
REQ-026 pc=15, 63, 64, 255 -> ir=0000 one edge later.
REQ-027 Read pc=12 (ir=3902), assert reset -> ir=0000 at once; release with pc=13 -> next edge ir=4204.
